// File: rtl/bcd_xs3_conv_if.sv
// Handshake bundle for the multi-digit BCD <-> Excess-3 converter.
// The producer/consumer side uses the master modport, the converter the slave modport.
interface bcd_xs3_conv_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [4*DIGITS-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_data;
  logic [DIGITS-1:0]     out_err_mask;
  logic                  out_err;

  modport master (
    output in_valid,
    input  in_ready,
    output in_mode,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_err_mask,
    input  out_err
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_mode,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_err_mask,
    output out_err
  );
endinterface

// File: rtl/bcd_xs3_conv.sv
// Multi-digit bidirectional BCD <-> Excess-3 converter, one digit per clock,
// least-significant digit first, with a per-digit invalid-code mask.
module bcd_xs3_conv #(
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_xs3_conv_if.slave    bus
);
  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {err, digit}; an invalid code passes through with err set.
  function automatic logic [4:0] conv_digit(input logic [3:0] d, input logic mode);
    logic [4:0] r;
    r = {1'b1, d};
    if (mode == 1'b0) begin
      if (d <= 4'd9) begin
        r = {1'b0, d + 4'd3};
      end else begin
        r = {1'b1, d};
      end
    end else begin
      if ((d >= 4'd3) && (d <= 4'd12)) begin
        r = {1'b0, d - 4'd3};
      end else begin
        r = {1'b1, d};
      end
    end
    return r;
  endfunction

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [W-1:0]      work_r;
  logic              mode_r;
  logic [W-1:0]      res_r;
  logic [DIGITS-1:0] mask_r;
  logic              valid_r;
  logic              err_r;

  logic [4:0]        conv_s;
  logic [W-1:0]      res_nxt_s;
  logic [DIGITS-1:0] mask_nxt_s;

  // Convert the current low digit of the work register and drop it into slot cnt.
  always_comb begin
    conv_s     = conv_digit(work_r[3:0], mode_r);
    res_nxt_s  = res_r;
    mask_nxt_s = mask_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_r == CNT_W'(i)) begin
        res_nxt_s[4*i +: 4] = conv_s[3:0];
        mask_nxt_s[i]       = conv_s[4];
      end else begin
        res_nxt_s[4*i +: 4] = res_r[4*i +: 4];
        mask_nxt_s[i]       = mask_r[i];
      end
    end
  end

  // Control FSM with the result registers; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      work_r  <= '0;
      mode_r  <= 1'b0;
      res_r   <= '0;
      mask_r  <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            work_r  <= bus.in_data;
            mode_r  <= bus.in_mode;
            res_r   <= '0;
            mask_r  <= '0;
            err_r   <= 1'b0;
            cnt_r   <= '0;
            state_r <= ST_CONV;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CONV: begin
          work_r <= work_r >> 4'd4;
          res_r  <= res_nxt_s;
          mask_r <= mask_nxt_s;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DONE;
            valid_r <= 1'b1;
            err_r   <= |mask_nxt_s;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Ready is gated by reset so it reads low for the whole reset interval.
  assign bus.in_ready     = rst_n & (state_r == ST_IDLE);
  assign bus.out_valid    = valid_r;
  assign bus.out_data     = res_r;
  assign bus.out_err_mask = mask_r;
  assign bus.out_err      = err_r;
endmodule
